dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, data memory address width.
REQ-002 Parameter DATA_W, default 32, data memory word width.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive grants to one port while the other port is requesting; legal range 1..15.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock, shared with data_memory.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req0, req1  input  1 each  access request from port 0 (CPU load/store) and port 1 (loader/DMA).
REQ-008 we0, we1  input  1 each  1 = write, 0 = read, qualified by reqN.
REQ-009 addr0, addr1  input  ADDR_W each  word address.
REQ-010 wdata0, wdata1  input  DATA_W each  write data.
REQ-011 gnt0, gnt1  output  1 each  command of that port is issued to memory this cycle.
REQ-012 rdata0, rdata1  output  DATA_W each  registered read data.
REQ-013 rvalid0, rvalid1  output  1 each  one-cycle pulse, rdataN updated.
REQ-014 mem_address  output  ADDR_W  to data_memory address.
REQ-015 mem_inData  output  DATA_W  to data_memory inData.
REQ-016 mem_memRead, mem_memWrite  output  1 each  to data_memory memRead/memWrite.
REQ-017 mem_outData  input  DATA_W  from data_memory outData; valid in the same cycle as mem_memRead.

Function
REQ-018 At most one of gnt0/gnt1 SHALL be high in any cycle; grants are combinational from req inputs and registered state.
REQ-019 A requester SHALL hold reqN, weN, addrN, wdataN stable until it samples gntN high at a rising edge; each gnt cycle is exactly one memory access.
REQ-020 State machine states: IDLE (no grant last cycle), OWN0, OWN1 (port granted last cycle); next state = OWN of this cycle's grantee, else IDLE.
REQ-021 A 4-bit burst counter SHALL be 1 on the first grant to a new owner, increment on each consecutive grant to the same owner, saturate at 15, and clear to 0 in IDLE.
REQ-022 Only one port requesting: that port SHALL be granted regardless of the burst counter.
REQ-023 Both requesting in IDLE: port 0 SHALL be granted.
REQ-024 Both requesting in OWNk: port k SHALL be granted if counter < MAX_BURST, else the other port.
REQ-025 During a grant the mem_* outputs SHALL carry the grantee's addr/wdata, mem_memWrite = weN, mem_memRead = not weN.
REQ-026 With no grant, mem_memRead, mem_memWrite, mem_address and mem_inData SHALL all be 0.
REQ-027 For a granted read, mem_outData SHALL be captured into rdataN at that rising edge and rvalidN pulses high the following cycle (latency 1).
REQ-028 rdataN SHALL hold its value until the next completed read by the same port; a write SHALL not change rdata or rvalid.
REQ-029 Back-to-back reads by one port SHALL give rvalidN high on consecutive cycles with the corresponding data.
REQ-030 A read granted in the cycle right after a write to the same address SHALL return the new data.

Reset
REQ-031 While rst_n is low: gnt0/gnt1, mem_memRead/mem_memWrite, rvalid0/rvalid1 SHALL be 0, state SHALL be IDLE, counter 0, rdata0/rdata1 0.
REQ-032 Reset asserted mid-burst SHALL drop grants immediately and discard any pending rvalid; after release, arbitration restarts from IDLE.

Structure
REQ-033 Package dm_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1), the burst-counter width and default ADDR_W/DATA_W.
REQ-034 The winner selection (REQ-022..024) SHALL be a combinational sub-module dm_arb_pick; datapath muxing and registers stay in dm_arbiter.

Verification
REQ-035 Port 0 writes 10 to address 0, then reads address 0 -> gnt0 on each cycle, rvalid0 one cycle after the read with rdata0 = 10; rvalid1 stays 0.
REQ-036 Both ports request from IDLE continuously, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,...
REQ-037 Port 1 writes 0xDEADBEEF to address 1 while port 0 reads address 1 in the next cycle -> rdata0 = 0xDEADBEEF.
REQ-038 Port 0 alone requests 10 consecutive reads -> gnt0 every cycle, no forced yield, 10 rvalid0 pulses in order.
REQ-039 rst_n pulsed low during the third cycle of a port 1 burst -> gnt1, mem_memWrite, rvalid1 low immediately; first grant after release goes to port 0 when both request.
REQ-040 No request for 3 cycles -> all mem_* outputs 0, state IDLE, rdata0/rdata1 unchanged.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the ownership state encoding, burst-counter width and default bus widths.
package dm_arb_pkg;

    localparam int CNT_W      = 4;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner selection between the two memory ports.
// A lone requester always wins; on contention the burst limit decides.
module dm_arb_pick
    import dm_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             i_req0,
    input  logic             i_req1,
    input  arb_state_e       i_state,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_pick0,
    output logic             o_pick1
);

    logic w_under;
    assign w_under = (i_cnt < CNT_W'(MAX_BURST));

    always_comb begin
        o_pick0 = 1'b0;
        o_pick1 = 1'b0;
        if (i_req0 && i_req1) begin
            // Owner keeps the port until it has used up its burst allowance.
            case (i_state)
                OWN0: begin
                    o_pick0 = w_under;
                    o_pick1 = !w_under;
                end
                OWN1: begin
                    o_pick1 = w_under;
                    o_pick0 = !w_under;
                end
                default: o_pick0 = 1'b1;
            endcase
        end else begin
            o_pick0 = i_req0;
            o_pick1 = i_req1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single-ported data memory (CPU port 0, loader/DMA port 1).
// Grants are combinational; read data is registered one cycle after the granted read.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_inData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_outData
);

    arb_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;
    logic             r_rvalid0, r_rvalid1;
    logic             w_pick0, w_pick1;
    logic             w_rd0, w_rd1;

    dm_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .i_req0  (req0),
        .i_req1  (req1),
        .i_state (r_state),
        .i_cnt   (r_cnt),
        .o_pick0 (w_pick0),
        .o_pick1 (w_pick1)
    );

    // Reset gates the grants directly so nothing reaches memory while rst_n is low.
    assign gnt0  = w_pick0 & rst_n;
    assign gnt1  = w_pick1 & rst_n;
    assign w_rd0 = gnt0 & !we0;
    assign w_rd1 = gnt1 & !we1;

    always_comb begin
        mem_address  = '0;
        mem_inData   = '0;
        mem_memRead  = 1'b0;
        mem_memWrite = 1'b0;
        if (gnt0) begin
            mem_address  = addr0;
            mem_inData   = wdata0;
            mem_memRead  = !we0;
            mem_memWrite = we0;
        end else if (gnt1) begin
            mem_address  = addr1;
            mem_inData   = wdata1;
            mem_memRead  = !we1;
            mem_memWrite = we1;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        if (gnt0)
            w_state_nxt = OWN0;
        else if (gnt1)
            w_state_nxt = OWN1;
        if (w_state_nxt != IDLE) begin
            if (w_state_nxt != r_state)
                w_cnt_nxt = CNT_W'(1);
            else if (r_cnt != CNT_SAT)
                w_cnt_nxt = r_cnt + CNT_W'(1);
            else
                w_cnt_nxt = r_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_rd0;
            r_rvalid1 <= w_rd1;
            if (w_rd0)
                r_rdata0 <= mem_outData;
            if (w_rd1)
                r_rdata1 <= mem_outData;
        end
    end

    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized bench for dm_arbiter against a cycle-level behavioural model of the arbitration rules.
// A simple memory model sits behind the mem_* port (write at the edge, combinational read).
module tb_dm_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_memRead, mem_memWrite;
    logic [DW-1:0] rdata0, rdata1, mem_inData, mem_outData;
    logic [AW-1:0] mem_address;

    logic [DW-1:0] mem [0:255];
    logic          mem_clr = 1'b1;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_address(mem_address), .mem_inData(mem_inData),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_outData(mem_outData)
    );

    always #5 clk = ~clk;

    assign mem_outData = mem[mem_address];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_memWrite) begin
            mem[mem_address] <= mem_inData;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:255];
    int            own;      // -1 none, else port granted last cycle
    int            burst;
    bit            exp_rv [2];
    logic [DW-1:0] exp_rd [2];
    int            last_g;
    bit            auto_en = 0;
    int            rate [2];
    int            n_chk = 0, n_fail = 0;
    int            gq [$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_port(bit r0, bit r1);
        if (!r0 && !r1) return -1;
        if (r0 != r1) return r0 ? 0 : 1;
        if (own < 0) return 0;
        return (burst < MB) ? own : 1 - own;
    endfunction

    task automatic model_reset();
        own = -1; burst = 0;
        exp_rv[0] = 0; exp_rv[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    task automatic new_req(input int p);
        bit go;
        go = ($urandom_range(0, 99) < rate[p]);
        if (p == 0) begin
            req0 = go; we0 = $urandom_range(0, 1); addr0 = AW'($urandom_range(0, 7)); wdata0 = $urandom;
        end else begin
            req1 = go; we1 = $urandom_range(0, 1); addr1 = AW'($urandom_range(0, 7)); wdata1 = $urandom;
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, then (optionally) drive new requests.
    task automatic step();
        int            g;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit            er, ew;
        @(negedge clk);
        g = pick_port(req0, req1);
        ea = '0; ed = '0; er = 0; ew = 0;
        if (g == 0) begin ea = addr0; ed = wdata0; ew = we0; er = !we0; end
        if (g == 1) begin ea = addr1; ed = wdata1; ew = we1; er = !we1; end
        chk("gnt0", DW'(gnt0), DW'(g == 0));
        chk("gnt1", DW'(gnt1), DW'(g == 1));
        chk("mem_address", DW'(mem_address), DW'(ea));
        chk("mem_inData", mem_inData, ed);
        chk("mem_memRead", DW'(mem_memRead), DW'(er));
        chk("mem_memWrite", DW'(mem_memWrite), DW'(ew));
        chk("rvalid0", DW'(rvalid0), DW'(exp_rv[0]));
        chk("rvalid1", DW'(rvalid1), DW'(exp_rv[1]));
        chk("rdata0", rdata0, exp_rd[0]);
        chk("rdata1", rdata1, exp_rd[1]);
        last_g = g;
        exp_rv[0] = 0; exp_rv[1] = 0;
        if (g >= 0 && er) begin
            exp_rv[g] = 1;
            exp_rd[g] = ref_mem[ea];
        end
        if (g >= 0 && ew) ref_mem[ea] = ed;
        if (g < 0) begin
            own = -1; burst = 0;
        end else if (g == own) begin
            burst = (burst < 15) ? burst + 1 : 15;
        end else begin
            own = g; burst = 1;
        end
        @(posedge clk); #1;
        if (auto_en) begin
            if (!req0 || last_g == 0) new_req(0);
            if (!req1 || last_g == 1) new_req(1);
        end
    endtask

    initial begin
        logic [DW-1:0] sv0, sv1;
        int            npulse;
        int            exp_seq [10];
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        model_reset();

        // Reset state, with both ports requesting to prove grants are gated
        req0 = 1; req1 = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gnt0", DW'(gnt0), '0);
        chk("rst_gnt1", DW'(gnt1), '0);
        chk("rst_memRead", DW'(mem_memRead), '0);
        chk("rst_memWrite", DW'(mem_memWrite), '0);
        chk("rst_rvalid0", DW'(rvalid0), '0);
        chk("rst_rvalid1", DW'(rvalid1), '0);
        chk("rst_rdata0", rdata0, '0);
        chk("rst_rdata1", rdata1, '0);
        req0 = 0; req1 = 0;
        mem_clr = 0;
        @(posedge clk); #1;
        rst_n = 1;

        // Port 0 write 10 to addr 0 then read it back
        req0 = 1; we0 = 1; addr0 = 0; wdata0 = 10;
        step();
        we0 = 0;
        step();
        chk("d1_rvalid0", DW'(rvalid0), 1);
        chk("d1_rdata0", rdata0, 10);
        chk("d1_rvalid1", DW'(rvalid1), 0);
        req0 = 0;
        step();

        // Both ports request continuously from IDLE
        req0 = 1; we0 = 0; addr0 = 2;
        req1 = 1; we1 = 0; addr1 = 3;
        gq.delete();
        for (int i = 0; i < 10; i++) begin
            step();
            gq.push_back(last_g);
        end
        for (int i = 0; i < 10; i++) chk($sformatf("burst_seq%0d", i), DW'(gq[i]), DW'(exp_seq[i]));
        req0 = 0; req1 = 0;
        step();

        // Port 1 writes, port 0 reads the same address next cycle
        req1 = 1; we1 = 1; addr1 = 1; wdata1 = 32'hDEADBEEF;
        step();
        req1 = 0; req0 = 1; we0 = 0; addr0 = 1;
        step();
        chk("raw_rdata0", rdata0, 32'hDEADBEEF);
        req0 = 0;
        step();

        // Port 0 alone: 10 back-to-back reads
        npulse = 0;
        req0 = 1; we0 = 0;
        for (int i = 0; i < 10; i++) begin
            addr0 = AW'(i);
            step();
            if (last_g == 0 && rvalid0) npulse++;
            chk($sformatf("b2b_rdata%0d", i), rdata0, ref_mem[i]);
        end
        chk("b2b_pulses", DW'(npulse), 10);
        req0 = 0;
        step();

        // Idle: three cycles with no request, read data retained
        sv0 = rdata0; sv1 = rdata1;
        repeat (3) step();
        chk("idle_rdata0", rdata0, sv0);
        chk("idle_rdata1", rdata1, sv1);

        // Reset during the third cycle of a port 1 burst
        req1 = 1; we1 = 0; addr1 = 4;
        step();
        addr1 = 5;
        step();
        we1 = 1; addr1 = 6; wdata1 = 32'h1234_5678;
        #2;
        chk("mid_gnt1_pre", DW'(gnt1), 1);
        chk("mid_memWrite_pre", DW'(mem_memWrite), 1);
        chk("mid_rvalid1_pre", DW'(rvalid1), 1);
        rst_n = 0;
        #1;
        chk("mid_gnt1", DW'(gnt1), 0);
        chk("mid_memWrite", DW'(mem_memWrite), 0);
        chk("mid_rvalid1", DW'(rvalid1), 0);
        chk("mid_rdata1", rdata1, 0);
        model_reset();
        req0 = 1; we0 = 0; addr0 = 6;
        we1 = 0;
        @(posedge clk); #1;
        rst_n = 1;
        step();
        chk("post_rst_first", DW'(last_g), 0);

        // Randomized traffic under several load mixes
        auto_en = 1;
        rate[0] = 60; rate[1] = 60;
        repeat (200) step();
        rate[0] = 25; rate[1] = 85;
        repeat (200) step();
        rate[0] = 100; rate[1] = 100;
        repeat (200) step();
        auto_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Mutual exclusion of grants checked every cycle
    always @(negedge clk) begin
        if (rst_n) chk("gnt_onehot", DW'(gnt0 & gnt1), 0);
    end

endmodule
